// File: rtl/wishbone_dm_regs_param.sv
// wishbone_dm_regs_param: Wishbone debug-module data/dmcontrol/dmstatus registers with event FIFO
module wishbone_dm_regs_param #(
  parameter int DATA_W    = 64,
  parameter int NUM_DATA  = 4,
  parameter int EVT_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  input  logic              halted_i,
  output logic              haltreq_o,
  output logic              resumereq_o,
  output logic              hartreset_o,
  output logic              evt_valid_o,
  output logic [7:0]        evt_code_o,
  input  logic              evt_ready_i,
  output logic              evt_overflow_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;
  localparam int AW = $clog2(EVT_DEPTH);
  logic [0:0]        state;
  logic [DATA_W-1:0] data_q [NUM_DATA];
  logic [31:0]       dmctl;
  logic              all_ack;
  logic [7:0]        evt_mem [EVT_DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       cnt;
  logic              start, wr, wr_ctl, wr_stat, resume_fire, push, pop, push_ok;
  logic [7:0]        push_code;
  logic [DATA_W-1:0] rd_val;
  logic [31:0]       dmstatus;
  logic [2:0]        rise;
  assign start       = state == IDLE && cyc_i && stb_i;
  assign wr          = start && we_i;
  assign wr_ctl      = wr && addr_i == 32'h10;
  assign wr_stat     = wr && addr_i == 32'h11;
  assign resume_fire = dmctl[30] && !halted_i;
  assign rise        = data_i[31:29] & ~dmctl[31:29];
  assign dmstatus    = {14'd0, all_ack, 5'd0, ~halted_i, 1'b0, halted_i, 1'b0, 1'b1, 3'd0, 4'd2};
  assign ack_o       = state == ACK;
  assign haltreq_o   = dmctl[31];
  assign resumereq_o = dmctl[30];
  assign hartreset_o = dmctl[29];
  assign evt_valid_o = cnt != '0;
  assign evt_code_o  = evt_mem[rp];
  assign pop         = evt_valid_o && evt_ready_i;
  assign push_ok     = push && (cnt != (AW+1)'(EVT_DEPTH) || pop);
  always_comb begin
    rd_val    = '0;
    push      = 1'b0;
    push_code = 8'h00;
    for (int k = 0; k < NUM_DATA; k++)
      if (addr_i == 32'(4 + k)) begin
        rd_val    = data_q[k];
        push      = wr && data_i != data_q[k];
        push_code = 8'(k);
      end
    if (addr_i == 32'h10) begin
      rd_val    = DATA_W'(dmctl);
      push      = wr && |rise;
      push_code = rise[2] ? 8'h10 : rise[1] ? 8'h11 : 8'h12;
    end
    if (addr_i == 32'h11) begin
      rd_val    = DATA_W'(dmstatus);
      push      = wr;
      push_code = 8'h20;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      data_o         <= '0;
      dmctl          <= '0;
      all_ack        <= 1'b0;
      wp             <= '0;
      rp             <= '0;
      cnt            <= '0;
      evt_overflow_o <= 1'b0;
      for (int k = 0; k < NUM_DATA; k++) data_q[k] <= '0;
    end else begin
      state  <= start ? ACK : (cyc_i && stb_i) ? state : IDLE;
      data_o <= start ? rd_val : (cyc_i && stb_i) ? data_o : '0;
      for (int k = 0; k < NUM_DATA; k++)
        if (wr && addr_i == 32'(4 + k)) data_q[k] <= data_i;
      if (wr_ctl) dmctl <= data_i[31:0];
      else if (resume_fire) dmctl[30] <= 1'b0;
      if (wr_ctl && data_i[30]) all_ack <= 1'b0;
      else if (resume_fire) all_ack <= 1'b1;
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt            <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
      evt_overflow_o <= wr_stat ? 1'b0 : (push && !push_ok) ? 1'b1 : evt_overflow_o;
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i && push_ok) evt_mem[wp] <= push_code;
endmodule

// File: tb/tb_wishbone_dm_regs_param.sv
// tb_wishbone_dm_regs_param: scoreboard bench for wishbone_dm_regs_param
module tb_wishbone_dm_regs_param;
  logic        clk_i = 1'b0;
  logic        rst_i, we_i, cyc_i, stb_i, halted_i, evt_ready_i;
  logic [31:0] addr_i;
  logic [63:0] data_i, data_o;
  logic        ack_o, haltreq_o, resumereq_o, hartreset_o, evt_valid_o, evt_overflow_o;
  logic [7:0]  evt_code_o;
  logic [63:0] exp_rd [$];
  logic [7:0]  exp_evt [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_ack = 1'b0;
  wishbone_dm_regs_param dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .data_i(data_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .data_o(data_o), .ack_o(ack_o), .halted_i(halted_i),
    .haltreq_o(haltreq_o), .resumereq_o(resumereq_o), .hartreset_o(hartreset_o),
    .evt_valid_o(evt_valid_o), .evt_code_o(evt_code_o), .evt_ready_i(evt_ready_i),
    .evt_overflow_o(evt_overflow_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge clk_i) begin
    if (ack_o === 1'b1 && !prev_ack) begin
      if (exp_rd.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no transfer", data_o);
      end else chk("rd_data", data_o, exp_rd.pop_front());
    end
    prev_ack = ack_o === 1'b1;
    if (evt_valid_o === 1'b1 && evt_ready_i) begin
      if (exp_evt.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL evt_unexpected: got %h expected no event", evt_code_o);
      end else chk("evt_code", 64'(evt_code_o), 64'(exp_evt.pop_front()));
    end
  end
  task automatic xfer(input logic [31:0] a, input logic w, input logic [63:0] d,
                      input int hold, input logic [63:0] pre);
    int acks = 0;
    exp_rd.push_back(pre);
    addr_i = a; we_i = w; data_i = d; cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
      @(posedge clk_i); #1;
    end
    chk("ack_cycles", 64'(acks), 64'(hold - 1));
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_release", 64'(ack_o), 64'd0);
    chk("data_idle", data_o, 64'd0);
  endtask
  task automatic drain();
    int n = 0;
    while (exp_evt.size() != 0 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("evt_drain", 64'(exp_evt.size()), 64'd0);
    chk("evt_empty", 64'(evt_valid_o), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    halted_i = 1'b1; evt_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_evt_valid", 64'(evt_valid_o), 64'd0);
    chk("rst_overflow", 64'(evt_overflow_o), 64'd0);
    chk("rst_ctl", {61'd0, haltreq_o, resumereq_o, hartreset_o}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    xfer(32'h11, 1'b0, 64'd0, 2, 64'h282);
    exp_evt.push_back(8'h00);
    xfer(32'h04, 1'b1, 64'h1122334455667788, 2, 64'd0);
    xfer(32'h04, 1'b0, 64'd0, 2, 64'h1122334455667788);
    exp_evt.push_back(8'h01);
    xfer(32'h05, 1'b1, 64'hA5A50000FFFF0001, 5, 64'd0);
    xfer(32'h05, 1'b1, 64'hA5A50000FFFF0001, 2, 64'hA5A50000FFFF0001);
    xfer(32'h05, 1'b0, 64'd0, 3, 64'hA5A50000FFFF0001);
    drain();
    exp_evt.push_back(8'h10);
    xfer(32'h10, 1'b1, 64'hC0000000, 2, 64'd0);
    chk("haltreq_set", 64'(haltreq_o), 64'd1);
    chk("resumereq_set", 64'(resumereq_o), 64'd1);
    xfer(32'h11, 1'b0, 64'd0, 2, 64'h282);
    halted_i = 1'b0;
    @(posedge clk_i); #1;
    chk("resumereq_clr", 64'(resumereq_o), 64'd0);
    chk("haltreq_hold", 64'(haltreq_o), 64'd1);
    xfer(32'h11, 1'b0, 64'd0, 2, 64'h20882);
    xfer(32'h10, 1'b0, 64'd0, 2, 64'h80000000);
    exp_evt.push_back(8'h12);
    xfer(32'h10, 1'b1, 64'h20000000, 2, 64'h80000000);
    chk("hartreset_set", 64'(hartreset_o), 64'd1);
    chk("haltreq_clr", 64'(haltreq_o), 64'd0);
    xfer(32'h10, 1'b1, 64'd0, 2, 64'h20000000);
    xfer(32'h3F, 1'b0, 64'd0, 2, 64'd0);
    xfer(32'h3F, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2, 64'd0);
    xfer(32'h04, 1'b0, 64'd0, 2, 64'h1122334455667788);
    drain();
    evt_ready_i = 1'b0;
    exp_evt.push_back(8'h00);
    xfer(32'h04, 1'b1, 64'h1, 2, 64'h1122334455667788);
    exp_evt.push_back(8'h01);
    xfer(32'h05, 1'b1, 64'h2, 2, 64'hA5A50000FFFF0001);
    exp_evt.push_back(8'h02);
    xfer(32'h06, 1'b1, 64'h3, 2, 64'd0);
    exp_evt.push_back(8'h03);
    xfer(32'h07, 1'b1, 64'h4, 2, 64'd0);
    chk("full_no_ovf", 64'(evt_overflow_o), 64'd0);
    xfer(32'h04, 1'b1, 64'h5, 2, 64'h1);
    xfer(32'h05, 1'b1, 64'h6, 2, 64'h2);
    chk("ovf_set", 64'(evt_overflow_o), 64'd1);
    chk("ovf_head", 64'(evt_code_o), 64'h00);
    chk("ovf_valid", 64'(evt_valid_o), 64'd1);
    xfer(32'h11, 1'b1, 64'd0, 2, 64'h20882);
    chk("ovf_clear", 64'(evt_overflow_o), 64'd0);
    evt_ready_i = 1'b1;
    drain();
    xfer(32'h04, 1'b0, 64'd0, 2, 64'h5);
    evt_ready_i = 1'b0;
    exp_rd.push_back(64'd0);
    addr_i = 32'h10; we_i = 1'b1; data_i = 64'h80000000; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_ack", 64'(ack_o), 64'd1);
    chk("rst_mid_evt", 64'(evt_valid_o), 64'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_ack_clr", 64'(ack_o), 64'd0);
    chk("rst_mid_ctl", 64'(haltreq_o), 64'd0);
    chk("rst_mid_fifo", 64'(evt_valid_o), 64'd0);
    chk("rst_mid_data", data_o, 64'd0);
    exp_rd.push_back(64'd0);
    exp_evt.push_back(8'h10);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("restart_ack", 64'(ack_o), 64'd1);
    chk("restart_halt", 64'(haltreq_o), 64'd1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    chk("restart_release", 64'(ack_o), 64'd0);
    evt_ready_i = 1'b1;
    drain();
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wishbone_dm_regs_param.md
WISHBONE_DM_REGS_PARAM -- requirements
Module: wishbone_dm_regs_param

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning bus and register data width (32 or 64).
REQ-002 SHALL have parameter NUM_DATA, default 4, meaning number of dm.data registers (1..12).
REQ-003 SHALL have parameter EVT_DEPTH, default 4, meaning event FIFO depth (power of 2, >=2).
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports addr_i in 32 (register index), we_i in 1, data_i in DATA_W, cyc_i in 1, stb_i in 1: Wishbone slave inputs.
REQ-007 SHALL have ports data_o out DATA_W (read data) and ack_o out 1 (transfer acknowledge).
REQ-008 SHALL have port halted_i  in  1  hart halted status.
REQ-009 SHALL have ports haltreq_o, resumereq_o, hartreset_o, each out 1, driven from dmcontrol bits 31, 30, 29.
REQ-010 SHALL have ports evt_valid_o out 1, evt_code_o out 8, evt_ready_i in 1, evt_overflow_o out 1: event stream (replaces printf toggles).

Function
REQ-011 SHALL map dm.data k at address 0x04+k (k < NUM_DATA), dmcontrol at 0x10, read-only dmstatus at 0x11; other addresses read 0, writes ignored.
REQ-012 SHALL use FSM states IDLE and ACK: IDLE->ACK on clock edge with cyc_i&stb_i=1; ACK->IDLE on edge with cyc_i=0 or stb_i=0.
REQ-013 SHALL drive ack_o=1 exactly while in ACK, i.e. first ack one cycle after strobe, held until master negates cyc_i or stb_i.
REQ-014 SHALL perform a write exactly once per transfer, on the IDLE->ACK edge; held strobe in ACK SHALL NOT rewrite.
REQ-015 SHALL register data_o on the IDLE->ACK edge with the pre-write value of the addressed register; data_o=0 in IDLE.
REQ-016 SHALL format dmstatus: [3:0]=2, [7]=1, [9]=halted_i, [11]=~halted_i, [17]=allresumeack, all other bits 0.
REQ-017 SHALL clear dmcontrol[30] (resumereq) and set allresumeack on the first cycle halted_i=0 while resumereq=1.
REQ-018 SHALL clear allresumeack on any dmcontrol write with bit 30=1; simultaneous clear and set SHALL resolve to set-by-write-cleared (write wins).
REQ-019 SHALL push event code k when data k is written with a value differing from its current value; equal writes push nothing.
REQ-020 SHALL push one event on a dmcontrol write where any of bits 31/30/29 go 0->1, code by priority 0x10 (halt) > 0x11 (resume) > 0x12 (reset).
REQ-021 SHALL push code 0x20 on any write to 0x11 and clear evt_overflow_o in that same cycle.
REQ-022 SHALL present FIFO head on evt_code_o with evt_valid_o=1 when non-empty; pop on evt_valid_o&evt_ready_i.
REQ-023 SHALL, when FIFO full and push requested without pop, drop the event and set evt_overflow_o sticky.
REQ-024 SHALL, when full with simultaneous push and pop, accept both with no overflow; when empty, ignore evt_ready_i.
REQ-025 SHALL wrap FIFO pointers modulo EVT_DEPTH and keep occupancy count width clog2(EVT_DEPTH)+1.
REQ-026 SHALL, when data_i is narrower than 32 bits of dmcontrol semantics (DATA_W=32), use data_i[31:0] unchanged; upper bits SHALL be 0 in reads when DATA_W=64 for dmcontrol/dmstatus.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, set state IDLE, ack_o=0, data_o=0, all data and dmcontrol registers 0, allresumeack=0, FIFO empty, evt_valid_o=0, evt_overflow_o=0.
REQ-028 SHALL, on reset asserted mid-transfer, abort without performing the pending write and return to IDLE; a still-held strobe after reset SHALL start a new transfer.

Verification
REQ-029 SHALL verify: write 0x1122334455667788 to 0x04, then read 0x04 -> ack one cycle after stb, read data_o=0x1122334455667788, one event 0x00.
REQ-030 SHALL verify: hold cyc/stb 5 cycles on write to 0x05 -> ack high 4 cycles, single write, single event 0x01; rewrite same value -> no event.
REQ-031 SHALL verify: dmcontrol write 0xC0000000 with halted_i=1 -> haltreq_o=1, resumereq_o=1, event 0x10; drop halted_i -> resumereq_o=0, dmstatus[17]=1.
REQ-032 SHALL verify: EVT_DEPTH+2 event writes, evt_ready_i=0 -> FIFO holds first EVT_DEPTH codes in order, evt_overflow_o=1; write 0x11 -> overflow 0.
REQ-033 SHALL verify: rst_i asserted during ACK of write to 0x10 -> dmcontrol=0, ack_o=0 next cycle, FIFO empty.
REQ-034 SHALL verify: read 0x3F and write 0x3F -> data_o=0, ack normal, no register change, no event.
